// File: rtl/bcd_seg_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) driving
// active-low 7-segment digits with leading-zero blanking, overflow dashes and flash.
module bcd_seg_display #(
    parameter int IN_W      = 8,
    parameter int DIGITS    = 3,
    parameter int BLANK_LZ  = 1,
    parameter int FLASH_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     value,
    input  logic                load,
    input  logic                flash_en,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] seg,
    output logic                overflow
);

    localparam int WORK_W = 4 * (DIGITS + 1);
    localparam int CNT_W  = $clog2(IN_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0011000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_seg();
        logic [7*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[7*i +: 7] = (i == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RESET = reset_seg();

    logic [1:0]          state;
    logic [IN_W-1:0]     shift_reg;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_adj;
    logic [CNT_W-1:0]    bit_cnt;
    logic                lost_msb;
    logic [FLASH_DIV:0]  flash_cnt;
    logic [7*DIGITS-1:0] seg_reg;
    logic [7*DIGITS-1:0] seg_next;
    logic                ovf_next;
    logic                upper_zero;

    // NOTE: every always_comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS + 1; i++)
            if (work[4*i +: 4] >= 4'd5)
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end

    // A 1 shifted out of the spare top digit means the value exceeded even DIGITS+1 digits.
    assign ovf_next = lost_msb || (work[WORK_W-1 -: 4] != 4'd0);

    always_comb begin
        seg_next   = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (work[4*i +: 4] == 4'd0);
            if (ovf_next)
                seg_next[7*i +: 7] = SEG_DASH;
            else if (BLANK_LZ != 0 && i > 0 && upper_zero)
                seg_next[7*i +: 7] = SEG_BLANK;
            else
                seg_next[7*i +: 7] = seg_of(work[4*i +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            work      <= '0;
            bit_cnt   <= '0;
            lost_msb  <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            seg_reg   <= SEG_RESET;
            flash_cnt <= '0;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift_reg <= value;
                        work      <= '0;
                        bit_cnt   <= CNT_W'(IN_W);
                        lost_msb  <= 1'b0;
                        state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    work      <= {work_adj[WORK_W-2:0], shift_reg[IN_W-1]};
                    shift_reg <= shift_reg << 1;
                    lost_msb  <= lost_msb | work_adj[WORK_W-1];
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    bcd      <= work[4*DIGITS-1:0];
                    overflow <= ovf_next;
                    seg_reg  <= seg_next;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CONV);
    assign seg  = (flash_en && flash_cnt[FLASH_DIV]) ? '1 : seg_reg;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: vector table, hand-written corner
// sequences and randomized values against an arithmetic reference model.
module tb_bcd_seg_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0011000, BL = 7'b1111111, DA = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  value_a = '0;
    logic        load_a = 1'b0, flash_en_a = 1'b0;
    logic        busy_a, done_a, overflow_a;
    logic [11:0] bcd_a;
    logic [20:0] seg_a;
    logic [9:0]  value_b = '0;
    logic        load_b = 1'b0, flash_en_b = 1'b0;
    logic        busy_b, done_b, overflow_b;
    logic [7:0]  bcd_b;
    logic [13:0] seg_b;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;

    bcd_seg_display #(.IN_W(8), .DIGITS(3), .BLANK_LZ(1), .FLASH_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .value(value_a), .load(load_a), .flash_en(flash_en_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a), .overflow(overflow_a)
    );

    bcd_seg_display #(.IN_W(10), .DIGITS(2), .BLANK_LZ(0), .FLASH_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .value(value_b), .load(load_b), .flash_en(flash_en_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b), .overflow(overflow_b)
    );

    typedef struct {
        int          which;
        int          value;
        logic [11:0] bcd;
        logic [20:0] seg;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain decimal arithmetic ----------------
    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            default: return 7'b0011000;
        endcase
    endfunction

    function automatic logic [19:0] model_bcd(input int v, input int nd);
        logic [19:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [34:0] model_seg(input int v, input int nd, input bit blank);
        logic [34:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            if (v >= pow10(nd))                       r[7*i +: 7] = DA;
            else if (blank && i > 0 && v / pow10(i) == 0) r[7*i +: 7] = BL;
            else                                      r[7*i +: 7] = digit_seg((v / pow10(i)) % 10);
        end
        return r;
    endfunction

    // Starts at a negedge, pulses load for one edge, returns at the negedge of the
    // done cycle (or after the budget). k counts edges after the load edge.
    task automatic convert(input int which, input int v, output int k, output int nbusy);
        if (which == 0) begin value_a = 8'(v);  load_a = 1'b1; end
        else            begin value_b = 10'(v); load_b = 1'b1; end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
        k = 0;
        nbusy = 0;
        while (!(which == 0 ? done_a : done_b) && k < 40) begin
            if (which == 0 ? busy_a : busy_b) nbusy++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_model(input int which, input int v);
        logic [19:0] eb;
        logic [34:0] es;
        if (which == 0) begin
            eb = model_bcd(v, 3);
            es = model_seg(v, 3, 1'b1);
            check("bcd_a", 64'(bcd_a), 64'(eb[11:0]));
            check("seg_a", 64'(seg_a), 64'(es[20:0]));
            check("ovf_a", 64'(overflow_a), 64'(v >= 1000));
        end else begin
            eb = model_bcd(v, 2);
            es = model_seg(v, 2, 1'b0);
            check("bcd_b", 64'(bcd_b), 64'(eb[7:0]));
            check("seg_b", 64'(seg_b), 64'(es[13:0]));
            check("ovf_b", 64'(overflow_b), 64'(v >= 100));
        end
    endtask

    initial begin
        vec_t tab[10];
        int   k, nb, v, w;
        logic [20:0] base;

        tab[0] = '{0,    9, 12'h009, {BL, BL, S9},   1'b0};
        tab[1] = '{0,  255, 12'h255, {S2, S5, S5},   1'b0};
        tab[2] = '{0,    0, 12'h000, {BL, BL, S0},   1'b0};
        tab[3] = '{0,  100, 12'h100, {S1, S0, S0},   1'b0};
        tab[4] = '{0,   10, 12'h010, {BL, S1, S0},   1'b0};
        tab[5] = '{1,  100, 12'h000, {7'd0, DA, DA}, 1'b1};
        tab[6] = '{1,   42, 12'h042, {7'd0, S4, S2}, 1'b0};
        tab[7] = '{1,   99, 12'h099, {7'd0, S9, S9}, 1'b0};
        tab[8] = '{1,    7, 12'h007, {7'd0, S0, S7}, 1'b0};
        tab[9] = '{1, 1023, 12'h023, {7'd0, DA, DA}, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy_a", 64'(busy_a), 64'(0));
        check("rst_done_a", 64'(done_a), 64'(0));
        check("rst_bcd_a",  64'(bcd_a),  64'(0));
        check("rst_seg_a",  64'(seg_a),  64'({BL, BL, S0}));
        check("rst_ovf_a",  64'(overflow_a), 64'(0));
        check("rst_seg_b",  64'(seg_b),  64'({S0, S0}));
        check("rst_bcd_b",  64'(bcd_b),  64'(0));
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            convert(tab[i].which, tab[i].value, k, nb);
            w = tab[i].which;
            check("latency", 64'(k), 64'(w == 0 ? 9 : 11));
            check("busy_len", 64'(nb), 64'(w == 0 ? 8 : 10));
            if (w == 0) begin
                check("tab_bcd_a", 64'(bcd_a), 64'(tab[i].bcd));
                check("tab_seg_a", 64'(seg_a), 64'(tab[i].seg));
                check("tab_ovf_a", 64'(overflow_a), 64'(tab[i].ovf));
            end else begin
                check("tab_bcd_b", 64'(bcd_b), 64'(tab[i].bcd[7:0]));
                check("tab_seg_b", 64'(seg_b), 64'(tab[i].seg[13:0]));
                check("tab_ovf_b", 64'(overflow_b), 64'(tab[i].ovf));
            end
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done_b), 64'(0));

        // Load while busy is ignored; value is not re-sampled
        value_a = 8'd7;
        load_a  = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        k = 0;
        repeat (3) begin @(negedge clk); k++; end
        check("busy_at_3", 64'(busy_a), 64'(1));
        value_a = 8'd200;
        load_a  = 1'b1;
        @(negedge clk);
        k++;
        load_a = 1'b0;
        while (!done_a && k < 40) begin @(negedge clk); k++; end
        check("ign_latency", 64'(k), 64'(9));
        check("ign_bcd", 64'(bcd_a), 64'(12'h007));
        // Load asserted in the done cycle is accepted
        convert(0, 200, k, nb);
        check("b2b_latency", 64'(k), 64'(9));
        check("b2b_bcd", 64'(bcd_a), 64'(12'h200));

        // Randomized conversions, mostly back-to-back
        for (int i = 0; i < 48; i++) begin
            w = i % 2;
            v = (w == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1023));
            convert(w, v, k, nb);
            check("rnd_latency", 64'(k), 64'(w == 0 ? 9 : 11));
            check_model(w, v);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("rnd_hold_done", 64'(w == 0 ? done_a : done_b), 64'(0));
                check_model(w, v);
            end
        end

        // Reset in the middle of a conversion
        value_a = 8'd123;
        load_a  = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 64'(busy_a), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy_a), 64'(0));
        check("mid_rst_bcd",  64'(bcd_a),  64'(0));
        check("mid_rst_seg",  64'(seg_a),  64'({BL, BL, S0}));
        check("mid_rst_ovf_b", 64'(overflow_b), 64'(0));
        nb = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a || busy_a) nb++;
        end
        check("mid_no_done", 64'(nb), 64'(0));

        // Flash: half-period of 4 clocks on dut_a
        convert(0, 5, k, nb);
        check("fl_bcd", 64'(bcd_a), 64'(12'h005));
        base = {BL, BL, S5};
        flash_en_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("flash_seg", 64'(seg_a), 64'(((edge_cnt % 8) >= 4) ? 21'h1FFFFF : base));
            check("flash_bcd", 64'(bcd_a), 64'(12'h005));
        end
        flash_en_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("steady_seg", 64'(seg_a), 64'(base));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
